// File: rtl/cache_sequencer_if.sv
// Bundle of the CPU-side request port, the physical-memory port, the datapath
// status/strobe signals and the performance counters of one cache_sequencer.
interface cache_sequencer_if #(
    parameter int CNT_W = 32
);
    // CPU-side request port
    logic             mem_read;
    logic             mem_write;
    logic             mem_resp;
    // Physical-memory port
    logic             pmem_read;
    logic             pmem_write;
    logic             pmem_resp;
    // Datapath status
    logic             is_hit;
    logic             is_dirty;
    // Datapath select and write strobes
    logic             is_allocate;
    logic             use_replace;
    logic             load_data;
    logic             load_tag;
    logic             load_dirty;
    logic             load_valid;
    logic             load_plru;
    logic             valid_in;
    logic             dirty_in;
    // Performance counters
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;
    logic [CNT_W-1:0] wb_count;

    // The sequencer is the responding side of the CPU request port.
    modport slave (
        input  mem_read, mem_write, pmem_resp, is_hit, is_dirty,
        output mem_resp, pmem_read, pmem_write, is_allocate, use_replace,
               load_data, load_tag, load_dirty, load_valid, load_plru,
               valid_in, dirty_in, hit_count, miss_count, wb_count
    );

    // CPU, memory and datapath as seen from outside the sequencer.
    modport master (
        output mem_read, mem_write, pmem_resp, is_hit, is_dirty,
        input  mem_resp, pmem_read, pmem_write, is_allocate, use_replace,
               load_data, load_tag, load_dirty, load_valid, load_plru,
               valid_in, dirty_in, hit_count, miss_count, wb_count
    );
endinterface

// File: rtl/cache_sequencer.sv
// Control FSM for a set-associative cache datapath: hit check, dirty-victim
// write-back, line allocation from physical memory, and saturating
// hit/miss/write-back performance counters.
module cache_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    cache_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        HIT_CHECK,
        WRITE_BACK,
        ALLOCATE,
        REFILL_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic             missed_q, missed_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [CNT_W-1:0] wb_q, wb_d;
    logic             req;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign req            = bus.mem_read | bus.mem_write;
    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
    assign bus.wb_count   = wb_q;

    // State, missed flag and counters; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            missed_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
            wb_q     <= '0;
        end else begin
            state_q  <= state_d;
            missed_q <= missed_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            wb_q     <= wb_d;
        end
    end

    // Next state, counter updates and all datapath/memory strobes.
    always_comb begin
        state_d         = state_q;
        missed_d        = missed_q;
        hit_d           = hit_q;
        miss_d          = miss_q;
        wb_d            = wb_q;
        bus.mem_resp    = 1'b0;
        bus.pmem_read   = 1'b0;
        bus.pmem_write  = 1'b0;
        bus.is_allocate = 1'b0;
        bus.use_replace = 1'b0;
        bus.load_data   = 1'b0;
        bus.load_tag    = 1'b0;
        bus.load_dirty  = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_plru   = 1'b0;
        bus.valid_in    = 1'b0;
        bus.dirty_in    = 1'b0;
        // Outputs are forced low for as long as reset is held.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    missed_d = 1'b0;
                    if (req) begin
                        state_d = HIT_CHECK;
                    end
                end
                HIT_CHECK: begin
                    if (!req) begin
                        // Request withdrawn (e.g. after a refill): serve nothing.
                        state_d = IDLE;
                    end else if (bus.is_hit) begin
                        bus.mem_resp  = 1'b1;
                        bus.load_plru = 1'b1;
                        if (bus.mem_write) begin
                            bus.load_data  = 1'b1;
                            bus.load_dirty = 1'b1;
                            bus.dirty_in   = 1'b1;
                        end
                        // A retry after a refill was already counted as a miss.
                        if (!missed_q) begin
                            hit_d = sat_inc(hit_q);
                        end
                        state_d = IDLE;
                    end else begin
                        missed_d = 1'b1;
                        miss_d   = sat_inc(miss_q);
                        state_d  = bus.is_dirty ? WRITE_BACK : ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    bus.pmem_write  = 1'b1;
                    bus.use_replace = 1'b1;
                    if (bus.pmem_resp) begin
                        bus.load_dirty = 1'b1;
                        wb_d           = sat_inc(wb_q);
                        state_d        = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    bus.pmem_read   = 1'b1;
                    bus.use_replace = 1'b1;
                    bus.is_allocate = 1'b1;
                    if (bus.pmem_resp) begin
                        bus.load_data  = 1'b1;
                        bus.load_tag   = 1'b1;
                        bus.load_valid = 1'b1;
                        bus.load_dirty = 1'b1;
                        bus.valid_in   = 1'b1;
                        state_d        = REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    // Arrays re-read the freshly written line before the retry.
                    state_d = HIT_CHECK;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_sequencer.sv
// Bench for cache_sequencer: table of request transactions with a response
// scoreboard, plus hand-written reset, drop, idle-response and saturation cases.
module tb_cache_sequencer;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;

    cache_sequencer_if #(.CNT_W(CW)) bus ();

    cache_sequencer #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rd;
        bit       wr;
        bit       hit;
        bit       dirty;
        int       lat;
        logic [7:0] sig;
        int       cyc;
        int       erd;
        int       ewb;
        int       dh;
        int       dm;
        int       dw;
    } vec_t;

    typedef struct {
        logic [7:0] sig;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];
    int   n_vec = 0;
    int   n_bad = 0;
    int   tot_hit = 0;
    int   tot_miss = 0;
    int   tot_wb = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // {load_plru, load_data, load_dirty, dirty_in, load_tag, load_valid, valid_in, is_allocate}
    function automatic logic [7:0] sig_now();
        return {bus.load_plru, bus.load_data, bus.load_dirty, bus.dirty_in,
                bus.load_tag, bus.load_valid, bus.valid_in, bus.is_allocate};
    endfunction

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic check_all_low(input string name);
        check(name, {sig_now(), bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.use_replace}, 12'h000);
    endtask

    task automatic check_counters(input string name);
        check({name, "_hit"},  bus.hit_count,  tot_hit);
        check({name, "_miss"}, bus.miss_count, tot_miss);
        check({name, "_wb"},   bus.wb_count,   tot_wb);
    endtask

    // Runs one request from IDLE. Entered and left at posedge+1.
    // drop_at < 0 keeps the request until mem_resp; otherwise it is withdrawn
    // from that cycle on and the transaction ends a few cycles after the refill.
    task automatic run_txn(input bit rd, input bit wr, input bit hit, input bit dirty,
                           input int lat, input int drop_at, input bit expect_resp,
                           input logic [7:0] esig, input int ecyc, input int erd, input int ewb);
        bit refilled = 1'b0;
        bit wbdone   = 1'b0;
        bit done     = 1'b0;
        bit resp_seen = 1'b0;
        bit plru_after = 1'b0;
        int pend = 0;
        int cyc = 0;
        int rd_cyc = 0;
        int wb_cyc = 0;
        int post = 0;
        exp_t e;
        if (expect_resp) begin
            e.sig = esig;
            e.cyc = ecyc;
            sb.push_back(e);
        end
        while (!done && cyc < 60) begin
            bus.mem_read  = rd && (drop_at < 0 || cyc < drop_at);
            bus.mem_write = wr && (drop_at < 0 || cyc < drop_at);
            bus.is_hit    = hit || refilled;
            bus.is_dirty  = dirty && !wbdone;
            bus.pmem_resp = (bus.pmem_read || bus.pmem_write) && (pend == lat - 1);
            #1;
            check("pmem_exclusive", bus.pmem_read & bus.pmem_write, 1'b0);
            if (bus.pmem_write) wb_cyc++;
            if (bus.pmem_read)  rd_cyc++;
            if (refilled && bus.load_plru) plru_after = 1'b1;
            if (bus.pmem_resp && bus.pmem_write) begin
                check("wb_resp_strobes",
                      {bus.load_dirty, bus.dirty_in, bus.use_replace, bus.is_allocate, bus.load_data},
                      5'b10100);
                wbdone = 1'b1;
            end
            if (bus.pmem_resp && bus.pmem_read) begin
                check("alloc_resp_strobes", {sig_now(), bus.use_replace}, {8'b0110_1111, 1'b1});
                refilled = 1'b1;
            end
            if (bus.pmem_read || bus.pmem_write) begin
                pend = bus.pmem_resp ? 0 : pend + 1;
            end
            if (bus.mem_resp) begin
                resp_seen = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_mem_resp", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("resp_strobes", sig_now(), e.sig);
                    check("resp_latency", cyc + 1, e.cyc);
                end
                done = 1'b1;
            end
            if (!expect_resp && refilled) begin
                post++;
                if (post > 3) done = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) check("txn_timeout", 1'b1, 1'b0);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.pmem_resp = 1'b0;
        bus.is_hit    = 1'b0;
        bus.is_dirty  = 1'b0;
        check("pmem_read_cycles", rd_cyc, erd);
        check("pmem_write_cycles", wb_cyc, ewb);
        if (!expect_resp) begin
            check("dropped_no_resp", resp_seen, 1'b0);
            check("dropped_no_plru", plru_after, 1'b0);
        end
    endtask

    initial begin
        //               rd    wr    hit   dirty lat sig    cyc erd ewb dh dm dw
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 8'h80, 8,  4,  0,  0, 1, 0}; // cold read miss
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 8'h80, 2,  0,  0,  1, 0, 0}; // read hit
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 8'hF0, 2,  0,  0,  1, 0, 0}; // write hit
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 3, 8'h80, 10, 3,  3,  0, 1, 1}; // dirty victim miss
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 8'hF0, 2,  0,  0,  1, 0, 0}; // read+write -> write
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 8'hF0, 6,  2,  0,  0, 1, 0}; // write miss clean
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 8'h80, 6,  1,  1,  0, 1, 1}; // fast dirty miss

        rst           = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.pmem_resp = 1'b0;
        bus.is_hit    = 1'b0;
        bus.is_dirty  = 1'b0;
        #2;
        check_all_low("reset_outputs");
        check_counters("reset_counters");

        // A hitting request while reset is held must produce nothing.
        bus.mem_read = 1'b1;
        bus.is_hit   = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_all_low("reset_held_request");
        bus.mem_read = 1'b0;
        bus.is_hit   = 1'b0;
        rst          = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].rd, tbl[i].wr, tbl[i].hit, tbl[i].dirty, tbl[i].lat, -1, 1'b1,
                    tbl[i].sig, tbl[i].cyc, tbl[i].erd, tbl[i].ewb);
            tot_hit  = sat(tot_hit + tbl[i].dh);
            tot_miss = sat(tot_miss + tbl[i].dm);
            tot_wb   = sat(tot_wb + tbl[i].dw);
            check_counters($sformatf("vec%0d", i));
        end

        // pmem_resp arriving in IDLE is ignored.
        bus.pmem_resp = 1'b1;
        #1;
        check_all_low("idle_pmem_resp");
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b0;
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 1, -1, 1'b1, 8'h80, 2, 0, 0);
        tot_hit = sat(tot_hit + 1);
        check_counters("after_idle_resp");

        // Request withdrawn during the allocate phase.
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 4, 3, 1'b0, 8'h00, 0, 4, 0);
        tot_miss = sat(tot_miss + 1);
        check_counters("after_drop");

        // Reset asserted mid-allocate, away from any clock edge.
        begin
            int guard = 0;
            bus.mem_read = 1'b1;
            bus.is_hit   = 1'b0;
            #1;
            while (!bus.pmem_read && guard < 10) begin
                @(posedge clk);
                #1;
                guard++;
            end
            check("reach_allocate", bus.pmem_read, 1'b1);
            #2;
            rst = 1'b1;
            #1;
            check("reset_drops_pmem_read", bus.pmem_read, 1'b0);
            check_all_low("reset_mid_alloc");
            tot_hit  = 0;
            tot_miss = 0;
            tot_wb   = 0;
            check_counters("reset_mid_alloc");
            bus.mem_read = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            #1;
            check_all_low("after_reset_idle");
            @(posedge clk);
            #1;
        end
        // A 2-cycle hit proves the FSM restarted from IDLE.
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 1, -1, 1'b1, 8'h80, 2, 0, 0);
        tot_hit = sat(tot_hit + 1);
        check_counters("post_reset_hit");

        // Hit counter saturation.
        for (int i = 0; i < 20; i++) begin
            run_txn(1'b1, 1'b0, 1'b1, 1'b0, 1, -1, 1'b1, 8'h80, 2, 0, 0);
        end
        check("hit_saturated", bus.hit_count, 4'd15);
        check("miss_after_sat", bus.miss_count, 4'd0);
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_sequencer.md
Name: cache_sequencer

Overview:
- Control FSM for the set-associative cache datapath (data/tag/valid/dirty/PLRU arrays); one instance per cache (I-cache, D-cache).
- Accepts one 256-bit line request at a time from the CPU-side port.
- Checks for a hit, writes back a dirty victim, allocates from physical memory, and drives every load/select strobe of the datapath.
- Maintains saturating hit/miss/writeback performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_read  in  1  CPU-side read request, held until mem_resp
- mem_write  in  1  CPU-side write request, held until mem_resp; wins if both asserted
- mem_resp  out  1  one-cycle request-complete pulse
- pmem_read  out  1  physical-memory line read request
- pmem_write  out  1  physical-memory line write request
- pmem_resp  in  1  physical-memory completion, one cycle
- is_hit  in  1  datapath: tag match on a valid way
- is_dirty  in  1  datapath: PLRU victim way is dirty
- is_allocate  out  1  datapath: select pmem_rdata, full mask, address tag
- use_replace  out  1  datapath: force PLRU victim way index
- load_data, load_tag, load_dirty, load_valid, load_plru  out  1 each  datapath write strobes
- valid_in, dirty_in  out  1 each  datapath valid/dirty write values
- hit_count, miss_count, wb_count  out  CNT_W each  performance counters

Behaviour:
- States: IDLE, HIT_CHECK, WRITE_BACK, ALLOCATE, REFILL_WAIT. Array reads are synchronous, so array outputs are valid one cycle after the address is presented.
- All strobe/request outputs are Moore/Mealy combinational from the state and inputs; each defaults to 0 in every state unless listed below.
- Reset: state=IDLE, missed flag=0, counters=0. All outputs are 0 while rst is high; the reset takes effect immediately, mid-transaction.
- IDLE:
  - mem_read|mem_write -> HIT_CHECK; otherwise stay.
  - Clear the missed flag.
- HIT_CHECK, is_hit=1, read:
  - mem_resp=1, load_plru=1 -> IDLE.
- HIT_CHECK, is_hit=1, write:
  - mem_resp=1, load_plru=1, load_data=1, load_dirty=1, dirty_in=1 -> IDLE.
- HIT_CHECK, is_hit=0:
  - Set the missed flag; miss_count++.
  - is_dirty=1 -> WRITE_BACK; else -> ALLOCATE.
- HIT_CHECK with neither mem_read nor mem_write asserted (request dropped during a miss):
  - -> IDLE, no strobes, no mem_resp.
- Hit latency: 2 cycles from request to mem_resp (IDLE, HIT_CHECK).
- WRITE_BACK:
  - pmem_write=1, use_replace=1, is_allocate=0 until pmem_resp.
  - On the pmem_resp cycle: load_dirty=1, dirty_in=0; wb_count++; -> ALLOCATE.
- ALLOCATE:
  - pmem_read=1, use_replace=1, is_allocate=1 until pmem_resp.
  - On the pmem_resp cycle: load_data, load_tag, load_valid, load_dirty all =1; valid_in=1, dirty_in=0; -> REFILL_WAIT.
- REFILL_WAIT:
  - One idle cycle so the arrays re-read the new line; -> HIT_CHECK.
  - The retry then hits, so the request is served and PLRU updated by the normal hit path.
- hit_count++ on a HIT_CHECK hit only if the missed flag=0, so each request counts as exactly one hit or one miss.
- All counters saturate at 2^CNT_W-1 with no wrap.
- pmem_read and pmem_write are never asserted in the same cycle.
- pmem_* remain held through the response cycle and are deasserted the following cycle.
- A pmem_resp that arrives in IDLE/HIT_CHECK/REFILL_WAIT is ignored.

Test Plan:
- Cold read miss on a clean set:
  - Expected sequence: IDLE -> HIT_CHECK -> ALLOCATE (pmem_read held 4 cycles until pmem_resp) -> REFILL_WAIT -> HIT_CHECK hit -> mem_resp.
  - Afterwards: miss_count=1, hit_count=0, wb_count=0.
- Repeat read to the same line:
  - mem_resp exactly 2 cycles after mem_read; load_plru=1 in that cycle; hit_count=1.
- Write hit:
  - load_data=load_dirty=dirty_in=load_plru=1 in one cycle with mem_resp.
  - A later conflicting miss to that set with the same victim goes to WRITE_BACK: pmem_write first, then pmem_read; wb_count=1.
- Reset during ALLOCATE with pmem_read high:
  - pmem_read drops in the same cycle as rst, before any clock edge.
  - State=IDLE and all counters=0 after release.
- mem_read and mem_write both high on a hit:
  - The write path is taken: load_data=1.
- Counter saturation (CNT_W=4):
  - 20 hits -> hit_count holds at 15.
- mem_read dropped mid-miss:
  - Refill completes, then HIT_CHECK -> IDLE with no mem_resp and no load_plru.
